// File: rtl/mmm_serial_datapath.sv
// Bit-serial Montgomery multiplier: P = A*B*2^-WIDTH mod M, one multiplier bit per enabled clock.
// Define MMM_FINAL_SUB_EN to include the final conditional subtraction (SUB state).
module mmm_serial_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             rst_mmm,
  input  logic             ld_a,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] p_out,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, SUB, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    w_t;
  logic [AW-1:0]    w_u;
  logic             w_last;

  function automatic logic [WIDTH-1:0] final_sub(input logic [AW-1:0] acc,
                                                 input logic [WIDTH-1:0] m);
    logic [AW-1:0] mx;
    mx = {2'b00, m};
    return WIDTH'((acc >= mx) ? (acc - mx) : acc);
  endfunction

  // One Montgomery iteration: add B if the current A bit is set, add M if odd, halve.
  assign w_t    = r_acc + (r_a_sr[0] ? {2'b00, r_b} : {AW{1'b0}});
  assign w_u    = w_t + (w_t[0] ? {2'b00, r_m} : {AW{1'b0}});
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    if (!rst_mmm) begin
      w_state_nxt = IDLE;
    end else if (ld_a) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
`ifdef MMM_FINAL_SUB_EN
        RUN:     if (w_last) w_state_nxt = SUB;
        SUB:     w_state_nxt = DONE;
`else
        RUN:     if (w_last) w_state_nxt = DONE;
`endif
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (ena) begin
      if (!rst_mmm) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (ld_a) begin
        r_a_sr <= a_in;
        r_b    <= b_in;
        r_m    <= m_in;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_acc  <= w_u >> 1;
        r_a_sr <= r_a_sr >> 1;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

`ifdef MMM_FINAL_SUB_EN
  logic [WIDTH-1:0] r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else if (ena && rst_mmm && !ld_a && (r_state == SUB)) begin
      r_p <= final_sub(r_acc, r_m);
    end
  end

  assign p_out = r_p;
  assign busy  = (r_state == RUN) || (r_state == SUB);
`else
  // Without the final subtraction the accumulator is the (unreduced) result.
  assign p_out = r_acc[WIDTH-1:0];
  assign busy  = (r_state == RUN);
`endif

  assign done = (r_state == DONE);

endmodule

// File: tb/tb_mmm_serial_datapath.sv
// Self-checking bench for mmm_serial_datapath against a modular-arithmetic reference model.
module tb_mmm_serial_datapath;

  localparam int WIDTH = 8;
`ifdef MMM_FINAL_SUB_EN
  localparam int LAT  = WIDTH + 1;
  localparam int MMAX = 255;
`else
  localparam int LAT  = WIDTH;
  localparam int MMAX = 127;
`endif

  logic             clk;
  logic             rst;
  logic             ena;
  logic             rst_mmm;
  logic             ld_a;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] m_in;
  logic [WIDTH-1:0] p_out;
  logic             done;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  mmm_serial_datapath #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .rst_mmm(rst_mmm), .ld_a(ld_a),
    .a_in(a_in), .b_in(b_in), .m_in(m_in),
    .p_out(p_out), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: the x in [0,M) with x*2^WIDTH == A*B (mod M).
  function automatic int ref_mmm(input int a, input int b, input int m);
    int ab, r2;
    ab = (a * b) % m;
    r2 = (1 << WIDTH) % m;
    for (int x = 0; x < m; x++)
      if ((x * r2) % m == ab) return x;
    return -1;
  endfunction

  // Acceptable product: exact when fully reduced, otherwise congruent and below 2M.
  function automatic bit p_ok(input int p, input int m, input int expv);
`ifdef MMM_FINAL_SUB_EN
    return p == expv;
`else
    return (p < 2 * m) && ((p % m) == expv);
`endif
  endfunction

  task automatic load(input int a, input int b, input int m);
    a_in = WIDTH'(a); b_in = WIDTH'(b); m_in = WIDTH'(m);
    ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
  endtask

  // Load and wait for done; lat is the number of edges after the ld_a edge (-1 on timeout).
  task automatic run_op(input int a, input int b, input int m, output int p, output int lat);
    load(a, b, m);
    lat = -1;
    for (int j = 1; j <= LAT + 4; j++) begin
      tick();
      if (done) begin
        lat = j;
        break;
      end
    end
    p = int'(p_out);
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b1; rst_mmm = 1'b1; ld_a = 1'b0;
    a_in = '0; b_in = '0; m_in = '0;
    tick(); tick();
    n_checks++;
    if ({p_out, done, busy} !== '0)
      $display("FAIL reset_in: p=%0d done=%0b busy=%0b, required 0/0/0", p_out, done, busy);
    else n_pass++;
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if ({p_out, done, busy} !== '0)
      $display("FAIL reset_idle: p=%0d done=%0b busy=%0b, required 0/0/0", p_out, done, busy);
    else n_pass++;
  endtask

  task automatic test_basic;
    int expv;
    expv = ref_mmm(5, 7, 13);
    load(5, 7, 13);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL basic_start: busy=%0b done=%0b, required 1/0", busy, done);
    else n_pass++;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      n_checks++;
      if (done !== (i == LAT) || busy !== (i < LAT))
        $display("FAIL basic_timing cyc%0d: done=%0b busy=%0b, required %0b/%0b",
                 i, done, busy, (i == LAT), (i < LAT));
      else n_pass++;
    end
    n_checks++;
    if (!p_ok(int'(p_out), 13, expv))
      $display("FAIL basic_p: p=%0d, required %0d (mod 13)", p_out, expv);
    else n_pass++;
  endtask

  task automatic test_final_sub;
    int a, m, p, lat, expv;
    m = (MMAX == 255) ? 251 : 127;
    a = m - 1;
    expv = ref_mmm(a, a, m);
    run_op(a, a, m, p, lat);
    n_checks++;
    if (lat != LAT || !p_ok(p, m, expv))
      $display("FAIL final_sub: p=%0d lat=%0d, required %0d lat=%0d", p, lat, expv, LAT);
    else n_pass++;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (int'(p_out) != p || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL final_sub_hold: p=%0d done=%0b busy=%0b, required %0d/1/0", p_out, done, busy, p);
    else n_pass++;
  endtask

  task automatic test_edge_values;
    int p, lat, m;
    m = (MMAX == 255) ? 251 : 127;
    run_op(0, 200 % m, m, p, lat);
    n_checks++;
    if (lat != LAT || p != 0)
      $display("FAIL zero_a: p=%0d lat=%0d, required 0 lat=%0d", p, lat, LAT);
    else n_pass++;
    run_op(1, 1, 13, p, lat);
    n_checks++;
    if (lat != LAT || !p_ok(p, 13, 3))
      $display("FAIL inv_r: p=%0d lat=%0d, required 3 lat=%0d", p, lat, LAT);
    else n_pass++;
  endtask

  task automatic test_ena_toggle;
    int en_edges, low_cnt, expv;
    bit bad;
    expv = ref_mmm(5, 7, 13);
    load(5, 7, 13);
    en_edges = 0; low_cnt = 0; bad = 0;
    for (int i = 0; i < 4 * LAT && en_edges < LAT + 1; i++) begin
      ena = ~ena;
      if (ena) en_edges++; else low_cnt++;
      tick();
      if (done !== (en_edges >= LAT)) bad = 1;
    end
    ena = 1'b1;
    n_checks++;
    if (bad || en_edges != LAT + 1)
      $display("FAIL ena_timing: done tracking wrong or edges=%0d, required %0d (low=%0d)",
               en_edges, LAT + 1, low_cnt);
    else n_pass++;
    n_checks++;
    if (!p_ok(int'(p_out), 13, expv))
      $display("FAIL ena_p: p=%0d, required %0d", p_out, expv);
    else n_pass++;
  endtask

  task automatic test_rst_mmm;
    int p, lat, expv;
    bit bad;
    load(5, 7, 13);
    for (int i = 0; i < 3; i++) tick();
    rst_mmm = 1'b0;
    tick();
    rst_mmm = 1'b1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mmm_clear: done=%0b busy=%0b, required 0/0", done, busy);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) $display("FAIL rst_mmm_idle: left IDLE without ld_a, done=%0b busy=%0b", done, busy);
    else n_pass++;
    run_op(5, 7, 13, p, lat);
    n_checks++;
    if (lat != LAT || !p_ok(p, 13, ref_mmm(5, 7, 13)))
      $display("FAIL rst_mmm_rerun: p=%0d lat=%0d, required 1 lat=%0d", p, lat, LAT);
    else n_pass++;
    load(5, 7, 13);
    tick(); tick(); tick();
    expv = ref_mmm(2, 3, 13);
    run_op(2, 3, 13, p, lat);
    n_checks++;
    if (lat != LAT || !p_ok(p, 13, expv))
      $display("FAIL restart: p=%0d lat=%0d, required %0d lat=%0d", p, lat, expv, LAT);
    else n_pass++;
  endtask

  task automatic test_async_rst;
    int p, lat;
    bit bad;
    load(5, 7, 13);
    tick(); tick(); tick();
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({p_out, done, busy} !== '0)
      $display("FAIL async_rst: p=%0d done=%0b busy=%0b, required 0/0/0", p_out, done, busy);
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if ({p_out, done, busy} !== '0) bad = 1;
    end
    n_checks++;
    if (bad) $display("FAIL async_rst_idle: activity after reset, p=%0d done=%0b busy=%0b", p_out, done, busy);
    else n_pass++;
    run_op(1, 1, 13, p, lat);
    n_checks++;
    if (lat != LAT || !p_ok(p, 13, 3))
      $display("FAIL async_rst_recover: p=%0d lat=%0d, required 3 lat=%0d", p, lat, LAT);
    else n_pass++;
  endtask

  task automatic test_random;
    int a, b, m, p, lat, expv;
    for (int n = 0; n < 40; n++) begin
      m = 2 * $urandom_range((MMAX - 1) / 2, 1) + 1;
      a = $urandom_range(m - 1, 0);
      b = $urandom_range(m - 1, 0);
      expv = ref_mmm(a, b, m);
      run_op(a, b, m, p, lat);
      n_checks++;
      if (lat != LAT || !p_ok(p, m, expv))
        $display("FAIL random %0d: A=%0d B=%0d M=%0d p=%0d lat=%0d, required %0d lat=%0d",
                 n, a, b, m, p, lat, expv, LAT);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_final_sub();
    test_edge_values();
    test_ena_toggle();
    test_rst_mmm();
    test_async_rst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmm_serial_datapath.md
Name: mmm_serial_datapath

Overview:
- Bit-serial Montgomery modular multiplier (MMM) datapath for the RSA exponentiation core.
- Sits directly downstream of the exponentiation control FSM. It consumes that FSM's `rst_mmm`/`ld_a` controls and muxed operands, and produces P = A·B·2^-WIDTH mod M.
- Retires one multiplier bit per enabled clock.
- Its result is captured by the FSM-driven result/lock registers.

Parameters:
- WIDTH, 8, operand/modulus bit width; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ena  in  1  clock enable; 0 freezes all state.
- rst_mmm  in  1  synchronous clear, active-low; from control FSM.
- ld_a  in  1  load operands and start a multiplication.
- a_in  in  WIDTH  multiplier A, < M.
- b_in  in  WIDTH  multiplicand B, < M.
- m_in  in  WIDTH  modulus M, odd.
- p_out  out  WIDTH  product, valid while done=1.
- done  out  1  result valid.
- busy  out  1  high in RUN/SUB.

Behaviour:
- Reset (rst=1, async): all of the following are 0.
  - Registers: a_sr, b_reg, m_reg, acc (WIDTH+2 bits), cnt ($clog2(WIDTH+1) bits), p_reg.
  - State = IDLE.
  - Outputs: p_out=0, done=0, busy=0.
- ena=0: every register holds, including state; the ld_a and rst_mmm inputs are ignored.
- Priority with ena=1: rst_mmm=0 > ld_a=1 > state action.
- rst_mmm=0:
  - acc=0, cnt=0, state=IDLE, done=0.
  - a_sr/b_reg/m_reg/p_reg hold.
  - Applies in any state, including mid-RUN.
- ld_a=1 (with rst_mmm=1):
  - Loads a_sr=a_in, b_reg=b_in, m_reg=m_in; acc=0, cnt=0, state=RUN, done=0.
  - Allowed in any state; restarts an in-flight operation.
- States:
  - IDLE: hold; done=0, busy=0.
  - RUN: one iteration per enabled cycle.
    - t = acc + (a_sr[0] ? b_reg : 0).
    - q = t[0].
    - acc <= (t + (q ? m_reg : 0)) >> 1.
    - a_sr <= a_sr >> 1; cnt <= cnt+1.
    - The iteration that moves cnt from WIDTH-1 to WIDTH also moves state to SUB.
  - SUB: p_reg <= (acc ≥ m_reg) ? acc − m_reg : acc, truncated to WIDTH bits; state=DONE.
  - DONE: done=1, busy=0; p_reg, acc and state hold until the next ld_a or rst_mmm=0.
- Width rules:
  - acc is WIDTH+2 bits, so the intermediate t + M (< 4M) never overflows.
  - After WIDTH iterations acc < 2M; a single subtraction yields p_out < M.
- Latency: ld_a sampled at edge k → iterations at edges k+1..k+WIDTH → SUB→DONE at edge k+WIDTH+1. done is high from edge k+WIDTH+1.
- p_out = p_reg in every state; it is only meaningful when done=1.
- busy = (state==RUN || state==SUB).
- Operands are only required to be stable in the ld_a cycle; they are not re-sampled afterwards.
- Out-of-contract inputs (M even, or A/B ≥ M): no hang; the FSM still reaches DONE after WIDTH+1 cycles, and p_out is unspecified.

Optional Feature:
- Macro: MMM_FINAL_SUB_EN.
- Defined: SUB state present, with behaviour as above; p_out < M guaranteed.
- Undefined:
  - SUB state removed; RUN transitions directly to DONE at cnt=WIDTH.
  - p_out = acc[WIDTH-1:0], unreduced, in [0, 2M).
  - done is high from edge k+WIDTH, one cycle earlier.
  - Caller must guarantee M < 2^(WIDTH-1).

Test Plan:
1. WIDTH=8, M=13, A=5, B=7, single ld_a pulse → done rises exactly 9 cycles after the ld_a edge; p_out=1; busy high for the 9 cycles. With the macro undefined: done after 8 cycles, p_out ≡ 1 mod 13.
2. M=251, A=250, B=250 (final subtraction path exercised) → p_out=201, done=1; p_out holds for 20 idle cycles.
3. A=0, B=200, M=251 → p_out=0; A=1, B=1, M=13 → p_out=3 (2^-8 mod 13).
4. Run M=13, A=5, B=7 with ena toggled 0/1 every cycle → same p_out=1; done delayed by exactly the number of ena-low cycles.
5. rst_mmm=0 for 1 cycle at iteration 4 → done=0, busy=0, state IDLE. A new ld_a with M=13, A=5, B=7 then gives p_out=1 after 9 cycles. A second ld_a issued mid-run with A=2, B=3 restarts the operation and yields 6·3 mod 13 = 5.
6. Assert rst mid-RUN and asynchronously between clock edges → p_out=0, done=0, busy=0 immediately. No activity until ld_a after rst is released.
